if_fetch: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues non-abortable requests to a variable-latency instruction memory.
- Buffers returned words in a 2-entry queue and presents {PC_4, DO} with valid_IF to IF/ID.
- Accepts jump/branch redirects from later stages and squashes wrong-path fetches.

---
 rtl/if_fetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, keeps one non-abortable request to imem in flight, buffers words in a 2-deep queue.
// Latency 1 cycle imem_ready->valid_IF; backpressure via enableIF, requests stop while the queue has no room.
module if_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        reloj,
  input  logic        resetIF,
  input  logic        enableIF,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_4,
  output logic [31:0] DO,
  output logic        valid_IF
);

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] instr;
  } fq_entry_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redir_pc, redir_pc_nxt;
  logic [1:0]  count;
  fq_entry_t   q0, q1;

  logic        pop, push, redir, space;
  logic [31:0] tgt;
  logic [2:0]  cnt_after_pop;

  always_comb begin
    pop           = valid_IF & enableIF;
    redir         = jump | branch_taken;
    tgt           = (jump ? jump_target : branch_target) & ~32'd3;
    cnt_after_pop = {1'b0, count} - {2'b00, pop};
    space         = cnt_after_pop <= 3'(QDEPTH - 1);
    push          = 1'b0;
    state_nxt     = state;
    pc_nxt        = pc;
    redir_pc_nxt  = redir_pc;
    case (state)
      S_IDLE: begin
        if (redir) begin
          pc_nxt    = tgt;
          state_nxt = S_BUSY;
        end else if (space) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (redir && imem_ready) begin
          pc_nxt = tgt;
        end else if (redir) begin
          redir_pc_nxt = tgt;
          state_nxt    = S_DROP;
        end else if (imem_ready) begin
          push      = 1'b1;
          pc_nxt    = pc + 32'd4;
          // Only chain straight into the next request if the queue still has room after this push.
          state_nxt = (cnt_after_pop < 3'(QDEPTH - 1)) ? S_BUSY : S_IDLE;
        end
      end
      S_DROP: begin
        if (redir) redir_pc_nxt = tgt;
        if (imem_ready) begin
          pc_nxt    = redir ? tgt : redir_pc;
          state_nxt = S_BUSY;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge reloj or negedge resetIF) begin
    if (!resetIF) begin
      state    <= S_IDLE;
      pc       <= PC_RESET;
      redir_pc <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redir_pc <= redir_pc_nxt;
      count    <= redir ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head is always q0; a push lands behind whatever survives this cycle's pop.
  always_ff @(posedge reloj or negedge resetIF) begin
    if (!resetIF) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      if (pop) q0 <= q1;
      if (push) begin
        if (cnt_after_pop == 3'd0) q0 <= '{pc_4: pc + 32'd4, instr: imem_rdata};
        else                       q1 <= '{pc_4: pc + 32'd4, instr: imem_rdata};
      end
    end
  end

  assign imem_req  = (state != S_IDLE);
  assign imem_addr = pc;
  assign valid_IF  = (count != 2'd0);
  assign DO        = valid_IF ? q0.instr : '0;
  assign PC_4      = valid_IF ? q0.pc_4  : '0;

endmodule
